// File: rtl/tartaruga_pkg.sv
// ---------------------------------------------------------------------------
// tartaruga_pkg
//
// Shared types and constants for the tartaruga fetch-side instruction memory.
//
// Contents:
//   bus32_t           32-bit bus word
//   IMEM_DEPTH        default instruction memory size in 32-bit words
//   IMEM_MAX_LATENCY  deepest supported read latency
//   IMEM_BOOT_LEN     number of words in the built-in boot program
//   IMEM_BOOT_PROG    built-in boot program, loaded into the bottom words on
//                     reset when the memory is built with
//                     TARTARUGA_IMEM_BOOT_EN
//   imem_stage_t      one slot of the response delay line
//   imem_boot_word()  boot image lookup, zero beyond the program
// ---------------------------------------------------------------------------
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    localparam int IMEM_DEPTH       = 4096;
    localparam int IMEM_MAX_LATENCY = 4;
    localparam int IMEM_BOOT_LEN    = 14;

    // Small arithmetic smoke program: builds two constants in x1/x2 and
    // runs them through the R-type ALU operations.
    localparam bus32_t IMEM_BOOT_PROG [IMEM_BOOT_LEN] = '{
        32'h123450b7,   //  0: lui  x1, 0x12345
        32'h67808093,   //  1: addi x1, x1, 0x678
        32'h87654137,   //  2: lui  x2, 0x87654
        32'h32110113,   //  3: addi x2, x2, 0x321
        32'h002081b3,   //  4: add  x3, x1, x2
        32'h40208233,   //  5: sub  x4, x1, x2
        32'h0020f2b3,   //  6: and  x5, x1, x2
        32'h0020e333,   //  7: or   x6, x1, x2
        32'h0020c3b3,   //  8: xor  x7, x1, x2
        32'h00209433,   //  9: sll  x8, x1, x2
        32'h0020d4b3,   // 10: srl  x9, x1, x2
        32'h0020a533,   // 11: slt  x10, x1, x2
        32'h0020b5b3,   // 12: sltu x11, x1, x2
        32'h001171b3    // 13: and  x3, x2, x1
    };

    // One delay-line slot. valid marks a live response; instr is already
    // forced to zero for erroring requests.
    typedef struct packed {
        logic   valid;
        bus32_t instr;
        logic   err;
        bus32_t pc;
    } imem_stage_t;

    // Boot image value of word idx (zero above the boot program).
    function automatic bus32_t imem_boot_word(input int idx);
        bus32_t word;
        word = '0;
        if (idx >= 0 && idx < IMEM_BOOT_LEN) begin
            word = IMEM_BOOT_PROG[idx[3:0]];
        end
        return word;
    endfunction

endpackage

// File: rtl/tartaruga_imem_delay_line.sv
// ---------------------------------------------------------------------------
// imem_delay_line
//
// LATENCY-deep pipeline of imem_stage_t carrying fetch responses from the
// array read to the response port. The whole line advances together; it
// freezes while the output slot holds a valid response that the consumer has
// not taken. A flush kills every in-flight slot but still lets the slot-0
// input through, so the first fetch of a redirected path is not lost.
//
// Parameters:
//   LATENCY      number of slots, 1..IMEM_MAX_LATENCY
//
// Ports:
//   clk_i        in   clock
//   rstn_i       in   asynchronous active-low reset, clears every slot
//   i_stage      in   slot-0 input (valid = request accepted this cycle)
//   i_flush      in   drop all in-flight slots at the next edge
//   i_rsp_ready  in   consumer takes the output slot this cycle
//   o_stage      out  output slot, drives the response port
//   o_stall      out  output valid and not taken: whole line holds
// ---------------------------------------------------------------------------
module imem_delay_line
    import tartaruga_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  imem_stage_t i_stage,
    input  logic        i_flush,
    input  logic        i_rsp_ready,
    output imem_stage_t o_stage,
    output logic        o_stall
);

    logic w_stall;
    logic w_advance;

    // A flush always moves the line, even when stalled: the stalled output
    // response is discarded along with everything behind it.
    assign w_advance = ~w_stall | i_flush;

    for (genvar gi = 0; gi < LATENCY; gi++) begin : gen_stage
        imem_stage_t r_stage;
        imem_stage_t w_in;

        if (gi == 0) begin : gen_head
            // Slot 0 takes the freshly read word. A request is only accepted
            // when the line is not stalled, so under a stalled flush its
            // valid is already 0 here.
            assign w_in = i_stage;
        end else begin : gen_body
            always_comb begin
                w_in       = gen_stage[gi-1].r_stage;
                w_in.valid = gen_stage[gi-1].r_stage.valid & ~i_flush;
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_stage <= '0;
            end else if (w_advance) begin
                r_stage <= w_in;
            end
        end
    end

    assign o_stage = gen_stage[LATENCY-1].r_stage;
    assign w_stall = gen_stage[LATENCY-1].r_stage.valid & ~i_rsp_ready;
    assign o_stall = w_stall;

endmodule

// File: rtl/tartaruga_imem.sv
// ---------------------------------------------------------------------------
// tartaruga_imem
//
// Instruction memory for the fetch stage. Accepts one fetch request per cycle
// on a valid/ready port, reads the word array in the acceptance cycle and
// returns the result LATENCY cycles later, in order, on a valid/ready response
// port. Misaligned and out-of-range PCs return err=1 with a zero instruction
// and never touch the array. A separate write port loads the program.
//
// Build option:
//   TARTARUGA_IMEM_BOOT_EN  when defined, reset loads IMEM_BOOT_PROG into
//                           words 0..13 (rest zero); otherwise every word
//                           resets to zero and the program comes only through
//                           the write port.
//
// Parameters:
//   DEPTH        memory size in 32-bit words, power of two, >= 16
//   LATENCY      request acceptance to response valid, 1..4 cycles
//
// Ports:
//   clk_i        in   clock
//   rstn_i       in   asynchronous active-low reset
//   req_valid_i  in   fetch request valid
//   req_ready_o  out  request accepted when valid & ready
//   req_pc_i     in   byte address of the instruction
//   rsp_valid_o  out  response valid
//   rsp_ready_i  in   consumer accepts the response
//   rsp_instr_o  out  fetched instruction (0 on error)
//   rsp_err_o    out  request was misaligned or out of range
//   rsp_pc_o     out  PC of the request behind this response
//   flush_i      in   discard all in-flight responses (branch redirect)
//   wr_en_i      in   program-load write enable
//   wr_addr_i    in   word address to write
//   wr_data_i    in   data to write
// ---------------------------------------------------------------------------
module tartaruga_imem
    import tartaruga_pkg::*;
#(
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int LATENCY = 1
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  bus32_t                   req_pc_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output bus32_t                   rsp_instr_o,
    output logic                     rsp_err_o,
    output bus32_t                   rsp_pc_o,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  bus32_t                   wr_data_i
);

    localparam int AW = $clog2(DEPTH);

    bus32_t          r_mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic            w_misalign;
    logic            w_out_of_range;
    logic            w_err;
    bus32_t          w_rd_data;
    logic            w_accept;
    logic            w_stall;
    imem_stage_t     w_stage_in;
    imem_stage_t     w_stage_out;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    assign w_idx          = req_pc_i[2 +: AW];
    assign w_misalign     = |req_pc_i[1:0];
    // Any set bit above the word index means the word address is >= DEPTH.
    assign w_out_of_range = |(req_pc_i >> (AW + 2));
    assign w_err          = w_misalign | w_out_of_range;

    // Erroring requests read nothing, so a high PC never aliases onto a
    // low word.
    assign w_rd_data = w_err ? '0 : r_mem[w_idx];

    // -----------------------------------------------------------------------
    // Word array with program-load port. The read above sees the value from
    // before this cycle's write (read-first).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef TARTARUGA_IMEM_BOOT_EN
                r_mem[i[AW-1:0]] <= imem_boot_word(i);
`else
                r_mem[i[AW-1:0]] <= '0;
`endif
            end
        end else if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake and response pipeline
    // -----------------------------------------------------------------------
    assign req_ready_o = ~w_stall;
    assign w_accept    = req_valid_i & req_ready_o;

    always_comb begin
        w_stage_in       = '0;
        w_stage_in.valid = w_accept;
        w_stage_in.instr = w_rd_data;
        w_stage_in.err   = w_err;
        w_stage_in.pc    = req_pc_i;
    end

    imem_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay_line (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .i_stage     (w_stage_in),
        .i_flush     (flush_i),
        .i_rsp_ready (rsp_ready_i),
        .o_stage     (w_stage_out),
        .o_stall     (w_stall)
    );

    assign rsp_valid_o = w_stage_out.valid;
    assign rsp_instr_o = w_stage_out.instr;
    assign rsp_err_o   = w_stage_out.err;
    assign rsp_pc_o    = w_stage_out.pc;

endmodule
